// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module : gate_pkg
// Brief  : Shared types and constants for the AND-XOR gate self-test sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package gate_pkg;

  // Operand vector width: {a,b,c,d}
  localparam int VEC_W = 4;

  // Golden truth table of q = (a & b) ^ (c & d); bit i = q for {a,b,c,d} = i
  localparam logic [15:0] GATE_TRUTH_TABLE = 16'h7888;

  // Sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Priority encoder, LSB first; returns 0 when no bit is set
  function automatic logic [VEC_W-1:0] first_set_idx(input logic [15:0] v);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = VEC_W'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_settle_timer.sv
`default_nettype none
// ============================================================================
// Module : gate_settle_timer
// Brief  : Down-counter that measures how long each operand vector is held.
//          load_i presets the count; en_i counts down to zero and stops there.
// Rev    : 1.0 - initial release
// ============================================================================
module gate_settle_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] count_q;

  // Load takes priority over counting; the counter saturates at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expire_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : gate_sweep_ctrl
// Brief  : BIST controller for the AND-XOR gate. Sweeps all 16 operand
//          vectors, samples the gate output after a settle time, builds the
//          truth table and compares it against the golden table.
// Rev    : 1.0 - initial release
// ============================================================================
module gate_sweep_ctrl
  import gate_pkg::*;
#(
  parameter int unsigned  SETTLE_CYCLES = 1,
  parameter logic [15:0]  EXPECTED      = GATE_TRUTH_TABLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             gate_a,
  output logic             gate_b,
  output logic             gate_c,
  output logic             gate_d,
  input  logic             gate_q,
  output logic             busy,
  output logic             done,
  output logic [15:0]      table_out,
  output logic             pass,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_idx
);

  // The timer expires on the last SETTLE cycle, so it is preloaded with N-1
  localparam logic [VEC_W-1:0] SETTLE_LOAD = VEC_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [VEC_W-1:0] idx_q;
  logic [VEC_W-1:0] gate_vec_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      table_q;
  logic             pass_q;
  logic             fail_valid_q;
  logic [VEC_W-1:0] fail_idx_q;

  logic             w_timer_load;
  logic             w_timer_en;
  logic             w_expire;
  logic             w_last;
  logic [15:0]      w_table_next;
  logic [15:0]      w_diff;

  assign w_last = (idx_q == {VEC_W{1'b1}});

  // Table with the current sample merged in, and its mismatch mask
  always_comb begin
    w_table_next         = table_q;
    w_table_next[idx_q]  = gate_q;
    w_diff               = w_table_next ^ EXPECTED;
  end

  // Timer is reloaded whenever a new vector starts settling
  assign w_timer_load = ((state_q == ST_IDLE)   && start && !abort) ||
                        ((state_q == ST_SAMPLE) && !abort && !w_last);
  assign w_timer_en   = (state_q == ST_SETTLE);

  gate_settle_timer #(
    .WIDTH      (VEC_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_timer_load),
    .load_val_i (SETTLE_LOAD),
    .en_i       (w_timer_en),
    .expire_o   (w_expire)
  );

  // Sweep sequencer with registered outputs; abort returns to IDLE from any busy state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      gate_vec_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      table_q      <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_q      <= ST_SETTLE;
            idx_q        <= '0;
            gate_vec_q   <= '0;
            busy_q       <= 1'b1;
            table_q      <= '0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q      <= ST_IDLE;
            gate_vec_q   <= '0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
          end else if (w_expire) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state_q      <= ST_IDLE;
            gate_vec_q   <= '0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
          end else begin
            table_q <= w_table_next;
            if (w_last) begin
              state_q      <= ST_DONE;
              done_q       <= 1'b1;
              pass_q       <= (w_diff == '0);
              fail_valid_q <= |w_diff;
              fail_idx_q   <= first_set_idx(w_diff);
            end else begin
              state_q    <= ST_SETTLE;
              idx_q      <= idx_q + VEC_W'(1);
              gate_vec_q <= idx_q + VEC_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          gate_vec_q <= '0;
          busy_q     <= 1'b0;
          if (abort) begin
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gate_a     = gate_vec_q[3];
  assign gate_b     = gate_vec_q[2];
  assign gate_c     = gate_vec_q[1];
  assign gate_d     = gate_vec_q[0];
  assign busy       = busy_q;
  // An abort arriving during DONE cancels that cycle's completion pulse
  assign done       = done_q & ~abort;
  assign table_out  = table_q;
  assign pass       = pass_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_gate_sweep_ctrl
// Brief  : Self-checking bench for gate_sweep_ctrl with a behavioural
//          AND-XOR gate (optionally corrupted per vector) on each DUT.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  // DUT with SETTLE_CYCLES = 1
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic        a1, b1, c1, d1, q1, busy1, done1, pass1, fv1;
  logic [15:0] tbl1;
  logic [3:0]  fidx1;
  logic [3:0]  vec1;
  logic [15:0] flip_mask = 16'h0;

  // DUT with SETTLE_CYCLES = 3
  logic        start3 = 1'b0, abort3 = 1'b0;
  logic        a3, b3, c3, d3, q3, busy3, done3, pass3, fv3;
  logic [15:0] tbl3;
  logic [3:0]  fidx3;
  logic [3:0]  vec3;

  assign vec1 = {a1, b1, c1, d1};
  assign vec3 = {a3, b3, c3, d3};
  // Gate under test; flip_mask injects faults on selected vectors
  assign q1 = ((a1 & b1) ^ (c1 & d1)) ^ flip_mask[vec1];
  assign q3 = (a3 & b3) ^ (c3 & d3);

  gate_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .gate_a(a1), .gate_b(b1), .gate_c(c1), .gate_d(d1), .gate_q(q1),
    .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1),
    .fail_valid(fv1), .fail_idx(fidx1)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .gate_a(a3), .gate_b(b3), .gate_c(c3), .gate_d(d3), .gate_q(q3),
    .busy(busy3), .done(done3), .table_out(tbl3), .pass(pass3),
    .fail_valid(fv3), .fail_idx(fidx3)
  );

  typedef struct {
    logic [15:0] mask;
    logic [15:0] exp_table;
    logic        exp_pass;
    logic        exp_fv;
    logic [3:0]  exp_fidx;
  } vec_t;

  typedef struct {
    logic [15:0] exp_table;
    logic        exp_pass;
    logic        exp_fv;
    logic [3:0]  exp_fidx;
    int          start_cyc;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse of dut1 must match a queued expectation
  always @(negedge clk) begin
    if (!rst && done1 === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done1), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("table_out",  32'(tbl1),  32'(mon_e.exp_table));
        check("pass",       32'(pass1), 32'(mon_e.exp_pass));
        check("fail_valid", 32'(fv1),   32'(mon_e.exp_fv));
        check("fail_idx",   32'(fidx1), 32'(mon_e.exp_fidx));
        check("latency",    32'(cyc - mon_e.start_cyc), 32'd32);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input vec_t v);
    sb_t e;
    flip_mask   = v.mask;
    e.exp_table = v.exp_table;
    e.exp_pass  = v.exp_pass;
    e.exp_fv    = v.exp_fv;
    e.exp_fidx  = v.exp_fidx;
    e.start_cyc = cyc + 1;
    sb_q.push_back(e);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      tick();
      k++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic wait_vec1(input logic [3:0] v, input string name);
    int k;
    k = 0;
    while (!(busy1 && vec1 == v) && k < 200) begin
      tick();
      k++;
    end
    check(name, 32'(busy1 && vec1 == v), 32'd1);
  endtask

  initial begin
    int mism;
    int k;
    vecs[0] = '{16'h0000, 16'h7888, 1'b1, 1'b0, 4'd0};   // good gate
    vecs[1] = '{16'h7888, 16'h0000, 1'b0, 1'b1, 4'd3};   // q stuck at 0
    vecs[2] = '{16'hFFFF, 16'h8777, 1'b0, 1'b1, 4'd0};   // inverted gate
    vecs[3] = '{16'h8000, 16'hF888, 1'b0, 1'b1, 4'd15};  // fault on last vector only
    vecs[4] = '{16'h0010, 16'h7898, 1'b0, 1'b1, 4'd4};
    vecs[5] = '{16'h0A00, 16'h7288, 1'b0, 1'b1, 4'd9};   // two faults, lowest reported

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy",  32'(busy1), 32'd0);
    check("rst_done",  32'(done1), 32'd0);
    check("rst_gate",  32'(vec1),  32'd0);
    check("rst_table", 32'(tbl1),  32'd0);
    check("rst_pass",  32'(pass1), 32'd0);
    check("rst_fv",    32'(fv1),   32'd0);
    check("rst_fidx",  32'(fidx1), 32'd0);

    // Table-driven sweeps
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i]);
      drain("sweep_timeout");
      tick();
    end

    // Abort while idx = 5, then a fresh sweep must pass
    flip_mask = 16'h0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_vec1(4'd5, "reach_idx5");
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("abort_busy",  32'(busy1), 32'd0);
    check("abort_gate",  32'(vec1),  32'd0);
    check("abort_pass",  32'(pass1), 32'd0);
    check("abort_fv",    32'(fv1),   32'd0);
    check("abort_table", 32'(tbl1),  32'h0008);
    repeat (40) tick();
    launch(vecs[0]);
    drain("post_abort_timeout");
    tick();

    // start held every cycle during a sweep -> exactly one done
    launch(vecs[0]);
    start1 = 1'b1;
    repeat (29) tick();
    start1 = 1'b0;
    drain("restart_timeout");
    repeat (10) tick();
    check("restart_idle", 32'(busy1), 32'd0);

    // start and abort together in IDLE -> stay idle
    start1 = 1'b1;
    abort1 = 1'b1;
    tick();
    start1 = 1'b0;
    abort1 = 1'b0;
    check("start_abort_busy", 32'(busy1), 32'd0);
    repeat (3) tick();
    check("start_abort_busy2", 32'(busy1), 32'd0);
    check("start_abort_gate",  32'(vec1),  32'd0);

    // Reset mid-sweep at idx = 9
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_vec1(4'd9, "reach_idx9");
    rst = 1'b1;
    tick();
    check("mid_rst_busy",  32'(busy1), 32'd0);
    check("mid_rst_done",  32'(done1), 32'd0);
    check("mid_rst_gate",  32'(vec1),  32'd0);
    check("mid_rst_table", 32'(tbl1),  32'd0);
    check("mid_rst_pass",  32'(pass1), 32'd0);
    check("mid_rst_fv",    32'(fv1),   32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("mid_rst_stay_idle", 32'(busy1), 32'd0);

    // Abort during DONE suppresses the pulse and clears the verdict
    flip_mask = 16'h0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    k = 0;
    while (done1 !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("reach_done", 32'(done1), 32'd1);
    abort1 = 1'b1;
    #1;
    check("done_suppressed", 32'(done1), 32'd0);
    tick();
    abort1 = 1'b0;
    check("done_abort_pass", 32'(pass1), 32'd0);
    check("done_abort_fv",   32'(fv1),   32'd0);
    check("done_abort_busy", 32'(busy1), 32'd0);
    repeat (5) tick();

    // SETTLE_CYCLES = 3: each vector held 4 cycles, done at start + 64
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    mism = 0;
    for (int j = 0; j < 64; j++) begin
      if (vec3 !== 4'(j / 4) || busy3 !== 1'b1 || done3 !== 1'b0) mism++;
      tick();
    end
    check("s3_sequence_mismatches", 32'(mism), 32'd0);
    check("s3_done",  32'(done3), 32'd1);
    check("s3_table", 32'(tbl3),  32'h7888);
    check("s3_pass",  32'(pass3), 32'd1);
    check("s3_fv",    32'(fv3),   32'd0);
    tick();
    check("s3_idle",  32'(busy3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
